// File: rtl/bsg_mcl_arb_pkg.sv
// Shared types and width helpers for the manycore-link word arbiter.
//   arb_state_e  : arbiter FSM encoding (IDLE = arbitrate, BURST = grant locked)
//   safe_clog2   : index width that never collapses to zero bits
//   width_of     : bits needed to hold the value max_val itself (0..max_val)
package bsg_mcl_arb_pkg;

    typedef enum logic [0:0] {
        ARB_IDLE  = 1'b0,
        ARB_BURST = 1'b1
    } arb_state_e;

    function automatic int safe_clog2(input int n);
        return (n <= 1) ? 1 : $clog2(n);
    endfunction

    function automatic int width_of(input int max_val);
        return (max_val <= 1) ? 1 : $clog2(max_val + 1);
    endfunction

endpackage

// File: rtl/bsg_mcl_word_arbiter_if.sv
// Word-path bundle between the host slot FIFOs, the arbiter and the SIPO.
//   v_i/data_i/ready_o      : per-requester word channel (requester -> arbiter)
//   v_o/data_o/ready_i      : merged word channel (arbiter -> SIPO)
//   grant_id_o              : requester owning the word on data_o
//   credit_return_i         : one packet retired for requester i
//   credits_o               : packed per-requester credit counts
//   busy_o                  : high while a packet burst is locked
//   dbg_state_o             : raw arbiter FSM state
// Handshake: a word moves on a cycle where valid and ready are both high;
// valid never waits on ready, ready may depend on valid.
// Modports: slave = arbiter side, master = requester/SIPO side.
interface bsg_mcl_word_arbiter_if
    import bsg_mcl_arb_pkg::*;
#(
    parameter int num_req_p         = 2,
    parameter int width_p           = 32,
    parameter int max_out_credits_p = 16
) ();

    localparam int gid_w_lp    = safe_clog2(num_req_p);
    localparam int credit_w_lp = width_of(max_out_credits_p);

    logic [num_req_p-1:0]             v_i;
    logic [num_req_p*width_p-1:0]     data_i;
    logic [num_req_p-1:0]             ready_o;
    logic                             v_o;
    logic [width_p-1:0]               data_o;
    logic                             ready_i;
    logic [gid_w_lp-1:0]              grant_id_o;
    logic [num_req_p-1:0]             credit_return_i;
    logic [num_req_p*credit_w_lp-1:0] credits_o;
    logic                             busy_o;
    logic [0:0]                       dbg_state_o;

    modport slave (
        input  v_i, data_i, ready_i, credit_return_i,
        output ready_o, v_o, data_o, grant_id_o, credits_o, busy_o, dbg_state_o
    );

    modport master (
        output v_i, data_i, ready_i, credit_return_i,
        input  ready_o, v_o, data_o, grant_id_o, credits_o, busy_o, dbg_state_o
    );

endinterface

// File: rtl/bsg_counter_up_down.sv
// Saturating up/down counter used for per-requester packet credits.
//   clk_i, reset_n_i : clock, async active-low reset (count returns to init_val_p)
//   up_i, down_i     : increment / decrement amounts applied in the same cycle
//   count_o          : current count, 0..max_val_p
// Simultaneous up and down net out. An increment that would exceed
// max_val_p is clamped at max_val_p and flagged by a sim assertion.
module bsg_counter_up_down
    import bsg_mcl_arb_pkg::*;
#(
    parameter int max_val_p  = 16,
    parameter int init_val_p = 16,
    parameter int max_step_p = 1
) (
    input  logic                               clk_i,
    input  logic                               reset_n_i,
    input  logic [width_of(max_step_p)-1:0]    up_i,
    input  logic [width_of(max_step_p)-1:0]    down_i,
    output logic [width_of(max_val_p)-1:0]     count_o
);

    localparam int cnt_w_lp = width_of(max_val_p);
    localparam logic [cnt_w_lp:0]   max_lp  = (cnt_w_lp + 1)'(max_val_p);
    localparam logic [cnt_w_lp-1:0] init_lp = cnt_w_lp'(init_val_p);

    logic [cnt_w_lp-1:0] count_q, count_d;
    logic [cnt_w_lp:0]   sum;
    logic                overflow;

    // One extra bit so the pre-clamp value can exceed max_val_p and be seen.
    always_comb begin
        sum = {1'b0, count_q} + (cnt_w_lp + 1)'(up_i);
        if (sum < (cnt_w_lp + 1)'(down_i)) begin
            sum = '0;
        end else begin
            sum = sum - (cnt_w_lp + 1)'(down_i);
        end
        overflow = (sum > max_lp);
        count_d  = overflow ? max_lp[cnt_w_lp-1:0] : sum[cnt_w_lp-1:0];
    end

    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            count_q <= init_lp;
        end else begin
            count_q <= count_d;
        end
    end

    assign count_o = count_q;

    a_no_overflow: assert property (@(posedge clk_i) disable iff (!reset_n_i) !overflow)
        else $error("bsg_counter_up_down: increment past max_val_p");

endmodule

// File: rtl/bsg_mcl_rr_pick.sv
// Rotating-priority picker.
//   eligible_i : request vector
//   rr_ptr_i   : index with highest priority this cycle
//   winner_o   : first eligible index at rr_ptr_i, rr_ptr_i+1, ... (wrapping)
//   found_o    : any request eligible
// Purely combinational; winner_o is 0 when nothing is eligible.
module bsg_mcl_rr_pick
    import bsg_mcl_arb_pkg::*;
#(
    parameter int num_req_p = 2
) (
    input  logic [num_req_p-1:0]             eligible_i,
    input  logic [safe_clog2(num_req_p)-1:0] rr_ptr_i,
    output logic [safe_clog2(num_req_p)-1:0] winner_o,
    output logic                             found_o
);

    localparam int id_w_lp = safe_clog2(num_req_p);

    always_comb begin
        int idx;
        idx      = 0;
        winner_o = '0;
        found_o  = 1'b0;
        for (int k = 0; k < num_req_p; k++) begin
            idx = int'(rr_ptr_i) + k;
            if (idx >= num_req_p) begin
                idx = idx - num_req_p;
            end
            if (!found_o && eligible_i[idx]) begin
                found_o  = 1'b1;
                winner_o = idx[id_w_lp-1:0];
            end
        end
    end

endmodule

// File: rtl/bsg_mcl_word_arbiter.sv
// Shares one word path into the 32->128 SIPO among num_req_p host slot
// FIFOs. Once a requester's first word is accepted the grant is locked for
// beats_p words so packets never interleave. Each requester holds a credit
// count of outstanding packets; a requester at zero credits cannot start a
// new packet (a burst already in progress always completes).
//   clk_i, reset_n_i : clock, async active-low reset
//   bus (slave)      : word channels, grant id, credit returns/counts, busy
module bsg_mcl_word_arbiter
    import bsg_mcl_arb_pkg::*;
#(
    parameter int num_req_p         = 2,
    parameter int width_p           = 32,
    parameter int beats_p           = 4,
    parameter int max_out_credits_p = 16
) (
    input  logic                   clk_i,
    input  logic                   reset_n_i,
    bsg_mcl_word_arbiter_if.slave  bus
);

    localparam int gid_w_lp    = safe_clog2(num_req_p);
    localparam int beat_w_lp   = safe_clog2(beats_p);
    localparam int credit_w_lp = width_of(max_out_credits_p);

    localparam logic [0:0] STATE_IDLE  = ARB_IDLE;
    localparam logic [0:0] STATE_BURST = ARB_BURST;

    localparam logic [gid_w_lp-1:0]  last_req_lp  = gid_w_lp'(num_req_p - 1);
    localparam logic [beat_w_lp-1:0] last_beat_lp = beat_w_lp'(beats_p - 1);

    if (beats_p < 1) begin : g_bad_beats
        $error("bsg_mcl_word_arbiter: beats_p must be >= 1");
    end
    if (num_req_p < 1) begin : g_bad_reqs
        $error("bsg_mcl_word_arbiter: num_req_p must be >= 1");
    end

    logic [0:0]           state_q, state_d;
    logic [gid_w_lp-1:0]  gnt_q, gnt_d;
    logic [beat_w_lp-1:0] beat_cnt_q, beat_cnt_d;
    logic [gid_w_lp-1:0]  rr_ptr_q, rr_ptr_d;

    logic [num_req_p-1:0]             eligible;
    logic [num_req_p-1:0]             consume;
    logic [credit_w_lp-1:0]           credits [num_req_p];
    logic [num_req_p*credit_w_lp-1:0] credits_flat;
    logic [gid_w_lp-1:0]              winner;
    logic                             found;

    logic [gid_w_lp-1:0]  sel;
    logic                 v_out;
    logic [num_req_p-1:0] ready_out;

    for (genvar i = 0; i < num_req_p; i++) begin : g_credit
        bsg_counter_up_down #(
            .max_val_p  (max_out_credits_p),
            .init_val_p (max_out_credits_p),
            .max_step_p (1)
        ) u_credit (
            .clk_i     (clk_i),
            .reset_n_i (reset_n_i),
            .up_i      (bus.credit_return_i[i]),
            .down_i    (consume[i]),
            .count_o   (credits[i])
        );
        assign eligible[i] = bus.v_i[i] & (credits[i] != '0);
        assign credits_flat[i*credit_w_lp +: credit_w_lp] = credits[i];
    end

    bsg_mcl_rr_pick #(
        .num_req_p (num_req_p)
    ) u_pick (
        .eligible_i (eligible),
        .rr_ptr_i   (rr_ptr_q),
        .winner_o   (winner),
        .found_o    (found)
    );

    // While reset is held the outputs are forced idle so no requester sees
    // a ready it could mistake for an accepted word.
    always_comb begin
        state_d    = state_q;
        gnt_d      = gnt_q;
        beat_cnt_d = beat_cnt_q;
        rr_ptr_d   = rr_ptr_q;
        consume    = '0;
        sel        = '0;
        v_out      = 1'b0;
        ready_out  = '0;
        if (reset_n_i) begin
            if (state_q == STATE_IDLE) begin
                // Grant is not sticky here: the winner is re-picked every
                // cycle until its first word is accepted.
                if (found) begin
                    sel               = winner;
                    v_out             = 1'b1;
                    ready_out[winner] = bus.ready_i;
                    if (bus.ready_i) begin
                        consume[winner] = 1'b1;
                        rr_ptr_d        = (winner == last_req_lp) ? '0 : winner + 1'b1;
                        if (beats_p == 1) begin
                            beat_cnt_d = '0;
                        end else begin
                            beat_cnt_d = beat_w_lp'(1);
                            gnt_d      = winner;
                            state_d    = STATE_BURST;
                        end
                    end
                end
            end else begin
                // Locked: other requesters and gnt's own credit count are
                // ignored until the last word of the packet moves.
                sel              = gnt_q;
                v_out            = bus.v_i[gnt_q];
                ready_out[gnt_q] = bus.ready_i;
                if (v_out && bus.ready_i) begin
                    if (beat_cnt_q == last_beat_lp) begin
                        beat_cnt_d = '0;
                        state_d    = STATE_IDLE;
                    end else begin
                        beat_cnt_d = beat_cnt_q + 1'b1;
                    end
                end
            end
        end
    end

    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            state_q    <= STATE_IDLE;
            gnt_q      <= '0;
            beat_cnt_q <= '0;
            rr_ptr_q   <= '0;
        end else begin
            state_q    <= state_d;
            gnt_q      <= gnt_d;
            beat_cnt_q <= beat_cnt_d;
            rr_ptr_q   <= rr_ptr_d;
        end
    end

    assign bus.v_o         = v_out;
    assign bus.data_o      = bus.data_i[sel*width_p +: width_p];
    assign bus.ready_o     = ready_out;
    assign bus.grant_id_o  = sel;
    assign bus.credits_o   = credits_flat;
    assign bus.busy_o      = (state_q == STATE_BURST);
    assign bus.dbg_state_o = state_q;

    a_v_o_known: assert property (@(posedge clk_i) disable iff (!reset_n_i) !$isunknown(bus.v_o))
        else $error("bsg_mcl_word_arbiter: v_o unknown");

endmodule

// File: tb/tb_bsg_mcl_word_arbiter.sv
module tb_bsg_mcl_word_arbiter;

    localparam int NUM_REQ  = 2;
    localparam int WIDTH    = 32;
    localparam int BEATS    = 4;
    localparam int MAX_CRED = 16;
    localparam int CW       = 5;

    // ---------------- clock / reset ----------------
    logic clk_i;
    logic reset_n_i;

    initial begin
        clk_i = 1'b0;
        forever #5 clk_i = ~clk_i;
    end

    bsg_mcl_word_arbiter_if #(
        .num_req_p         (NUM_REQ),
        .width_p           (WIDTH),
        .max_out_credits_p (MAX_CRED)
    ) bus ();

    bsg_mcl_word_arbiter #(
        .num_req_p         (NUM_REQ),
        .width_p           (WIDTH),
        .beats_p           (BEATS),
        .max_out_credits_p (MAX_CRED)
    ) dut (
        .clk_i     (clk_i),
        .reset_n_i (reset_n_i),
        .bus       (bus.slave)
    );

    // ---------------- scoreboard state ----------------
    int n_checks;
    int n_errors;
    logic [WIDTH-1:0] exp_q[$];
    int beat [NUM_REQ];
    int pkt  [NUM_REQ];

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    function automatic logic [WIDTH-1:0] word(input int r, input int p, input int b);
        return {16'hC0DE, 4'(r), 8'(p), 4'(b)};
    endfunction

    function automatic logic [CW-1:0] cred(input int r);
        return bus.credits_o[r*CW +: CW];
    endfunction

    task automatic push_pkt(input int r, input int p);
        for (int b = 0; b < BEATS; b++) exp_q.push_back(word(r, p, b));
    endtask

    task automatic clear_src();
        for (int r = 0; r < NUM_REQ; r++) begin
            beat[r] = 0;
            pkt[r]  = 0;
        end
    endtask

    // ---------------- driver tasks ----------------
    task automatic drive(input logic [NUM_REQ-1:0] v, input logic rdy, input logic [NUM_REQ-1:0] cret);
        @(negedge clk_i);
        bus.v_i             = v;
        bus.ready_i         = rdy;
        bus.credit_return_i = cret;
        for (int r = 0; r < NUM_REQ; r++) bus.data_i[r*WIDTH +: WIDTH] = word(r, pkt[r], beat[r]);
        #1;
    endtask

    // Score the word (if any) moving this cycle and advance the requester sources.
    task automatic retire();
        logic [WIDTH-1:0] e;
        if (bus.v_o && bus.ready_i) begin
            e = 'x;
            if (exp_q.size() != 0) e = exp_q.pop_front();
            check("sb_data", 64'(bus.data_o), 64'(e));
        end
        for (int r = 0; r < NUM_REQ; r++) begin
            if (bus.v_i[r] && bus.ready_o[r]) begin
                beat[r]++;
                if (beat[r] == BEATS) begin
                    beat[r] = 0;
                    pkt[r]++;
                end
            end
        end
    endtask

    task automatic run(input logic [NUM_REQ-1:0] v, input logic rdy, input logic [NUM_REQ-1:0] cret);
        drive(v, rdy, cret);
        retire();
    endtask

    task automatic do_reset();
        @(negedge clk_i);
        reset_n_i           = 1'b0;
        bus.v_i             = '0;
        bus.ready_i         = 1'b0;
        bus.credit_return_i = '0;
        bus.data_i          = '0;
        repeat (2) @(negedge clk_i);
        reset_n_i = 1'b1;
        clear_src();
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    // ---------------- tests ----------------
    initial begin
        logic [NUM_REQ-1:0] lock_gid;
        logic [7:0]         lock_busy;
        n_checks            = 0;
        n_errors            = 0;
        reset_n_i           = 1'b0;
        bus.v_i             = '0;
        bus.ready_i         = 1'b0;
        bus.credit_return_i = '0;
        bus.data_i          = '0;
        clear_src();

        // 1: reset state
        do_reset();
        drive(2'b00, 1'b1, 2'b00);
        check("rst_v_o",   64'(bus.v_o), 64'(0));
        check("rst_busy",  64'(bus.busy_o), 64'(0));
        check("rst_ready", 64'(bus.ready_o), 64'(0));
        check("rst_grant", 64'(bus.grant_id_o), 64'(0));
        check("rst_cred0", 64'(cred(0)), 64'(MAX_CRED));
        check("rst_cred1", 64'(cred(1)), 64'(MAX_CRED));
        check("rst_state", 64'(bus.dbg_state_o), 64'(0));
        retire();

        // 2: grant locked for a whole packet, then round-robin to R1
        push_pkt(0, 0);
        push_pkt(1, 0);
        lock_gid  = 2'b00;
        lock_busy = 8'b1110_1110;  // bit i = busy expected on cycle i
        for (int i = 0; i < 8; i++) begin
            drive(2'b11, 1'b1, 2'b00);
            lock_gid = (i < 4) ? 2'd0 : 2'd1;
            check("lock_v",     64'(bus.v_o), 64'(1));
            check("lock_grant", 64'(bus.grant_id_o), 64'(lock_gid));
            check("lock_busy",  64'(bus.busy_o), 64'(lock_busy[i]));
            retire();
        end
        drive(2'b00, 1'b1, 2'b00);
        check("lock_cred0", 64'(cred(0)), 64'(15));
        check("lock_cred1", 64'(cred(1)), 64'(15));
        check("lock_idle",  64'(bus.busy_o), 64'(0));
        retire();

        // 3: downstream stall and upstream gap inside a burst
        do_reset();
        push_pkt(0, 0);
        drive(2'b01, 1'b1, 2'b00);
        check("st_busy_b0", 64'(bus.busy_o), 64'(0));
        retire();
        drive(2'b01, 1'b1, 2'b00);
        check("st_busy_b1", 64'(bus.busy_o), 64'(1));
        retire();
        for (int i = 0; i < 5; i++) begin
            drive(2'b11, 1'b0, 2'b00);
            check("st_hold_v",     64'(bus.v_o), 64'(1));
            check("st_hold_data",  64'(bus.data_o), 64'(word(0, 0, 2)));
            check("st_hold_grant", 64'(bus.grant_id_o), 64'(0));
            check("st_hold_rdy",   64'(bus.ready_o), 64'(2'b00));
            check("st_hold_busy",  64'(bus.busy_o), 64'(1));
            retire();
        end
        drive(2'b01, 1'b1, 2'b00);
        check("st_busy_b2", 64'(bus.busy_o), 64'(1));
        retire();
        for (int i = 0; i < 2; i++) begin
            drive(2'b10, 1'b1, 2'b00);
            check("st_gap_v",     64'(bus.v_o), 64'(0));
            check("st_gap_grant", 64'(bus.grant_id_o), 64'(0));
            check("st_gap_rdy",   64'(bus.ready_o), 64'(2'b01));
            check("st_gap_busy",  64'(bus.busy_o), 64'(1));
            retire();
        end
        drive(2'b01, 1'b1, 2'b00);
        check("st_busy_b3", 64'(bus.busy_o), 64'(1));
        retire();
        drive(2'b00, 1'b1, 2'b00);
        check("st_end_busy", 64'(bus.busy_o), 64'(0));
        check("st_words",    64'(exp_q.size()), 64'(0));
        retire();

        // 4: credit exhaustion blocks R0, R1 proceeds, return re-enables R0
        do_reset();
        for (int p = 0; p < MAX_CRED; p++) push_pkt(0, p);
        for (int i = 0; i < MAX_CRED * BEATS; i++) run(2'b01, 1'b1, 2'b00);
        drive(2'b01, 1'b1, 2'b00);
        check("cr_blk_v",   64'(bus.v_o), 64'(0));
        check("cr_blk_rdy", 64'(bus.ready_o), 64'(0));
        check("cr_zero",    64'(cred(0)), 64'(0));
        retire();
        push_pkt(1, 0);
        drive(2'b11, 1'b1, 2'b00);
        check("cr_r1_v",     64'(bus.v_o), 64'(1));
        check("cr_r1_grant", 64'(bus.grant_id_o), 64'(1));
        retire();
        for (int i = 0; i < BEATS - 1; i++) run(2'b11, 1'b1, 2'b00);
        drive(2'b01, 1'b1, 2'b01);
        check("cr_wait_v", 64'(bus.v_o), 64'(0));
        retire();
        push_pkt(0, MAX_CRED);
        drive(2'b01, 1'b1, 2'b00);
        check("cr_ret_cred0", 64'(cred(0)), 64'(1));
        check("cr_ret_v",     64'(bus.v_o), 64'(1));
        check("cr_ret_grant", 64'(bus.grant_id_o), 64'(0));
        retire();
        for (int i = 0; i < BEATS - 1; i++) run(2'b01, 1'b1, 2'b00);
        drive(2'b00, 1'b1, 2'b00);
        check("cr_end_cred0", 64'(cred(0)), 64'(0));
        check("cr_end_cred1", 64'(cred(1)), 64'(15));
        retire();

        // 5: first beat coinciding with a credit return nets to no change
        do_reset();
        push_pkt(0, 0);
        for (int i = 0; i < BEATS; i++) run(2'b01, 1'b1, 2'b00);
        push_pkt(0, 1);
        drive(2'b01, 1'b1, 2'b01);
        check("sim_pre", 64'(cred(0)), 64'(15));
        retire();
        drive(2'b01, 1'b1, 2'b00);
        check("sim_post", 64'(cred(0)), 64'(15));
        retire();
        for (int i = 0; i < BEATS - 2; i++) run(2'b01, 1'b1, 2'b00);
        run(2'b00, 1'b1, 2'b01);
        drive(2'b00, 1'b1, 2'b00);
        check("sim_ret", 64'(cred(0)), 64'(16));
        retire();

        // 6: reset asserted mid-burst
        do_reset();
        push_pkt(0, 0);
        for (int i = 0; i < BEATS; i++) run(2'b01, 1'b1, 2'b00);
        exp_q.push_back(word(1, 0, 0));
        exp_q.push_back(word(1, 0, 1));
        drive(2'b11, 1'b1, 2'b00);
        check("mr_grant", 64'(bus.grant_id_o), 64'(1));
        retire();
        run(2'b11, 1'b1, 2'b00);
        @(negedge clk_i);
        reset_n_i = 1'b0;
        #1;
        check("mr_busy",  64'(bus.busy_o), 64'(0));
        check("mr_v",     64'(bus.v_o), 64'(0));
        check("mr_rdy",   64'(bus.ready_o), 64'(0));
        check("mr_state", 64'(bus.dbg_state_o), 64'(0));
        check("mr_cred0", 64'(cred(0)), 64'(MAX_CRED));
        check("mr_cred1", 64'(cred(1)), 64'(MAX_CRED));
        retire();
        clear_src();
        bus.v_i = '0;
        @(negedge clk_i);
        reset_n_i = 1'b1;
        push_pkt(0, 0);
        drive(2'b11, 1'b1, 2'b00);
        check("mr_next_grant", 64'(bus.grant_id_o), 64'(0));
        check("mr_next_busy",  64'(bus.busy_o), 64'(0));
        retire();
        for (int i = 0; i < BEATS - 1; i++) run(2'b11, 1'b1, 2'b00);
        run(2'b00, 1'b1, 2'b00);

        check("sb_left", 64'(exp_q.size()), 64'(0));
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
